// File: rtl/cpu_gen2_pkg.sv
// cpu_gen2_pkg: opcodes, FSM state encoding and instruction field positions
// shared by the cpu_gen2 core, its register file and its testbench.
package cpu_gen2_pkg;

  typedef logic [7:0] opcode_t;

  localparam opcode_t OP_ADD = 8'h01;
  localparam opcode_t OP_SUB = 8'h02;
  localparam opcode_t OP_AND = 8'h03;
  localparam opcode_t OP_OR  = 8'h04;
  localparam opcode_t OP_XOR = 8'h05;
  localparam opcode_t OP_SHL = 8'h06;
  localparam opcode_t OP_SHR = 8'h07;
  localparam opcode_t OP_LDI = 8'h10;
  localparam opcode_t OP_LD  = 8'h11;
  localparam opcode_t OP_ST  = 8'h12;
  localparam opcode_t OP_JMP = 8'h20;
  localparam opcode_t OP_BEQ = 8'h21;
  localparam opcode_t OP_BNE = 8'h22;
  localparam opcode_t OP_HLT = 8'hFF;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  // rs2 shares the low nibble of the imm/addr field
  localparam int OP_LSB      = 24;
  localparam int RD_LSB      = 20;
  localparam int RS1_LSB     = 16;
  localparam int RS2_LSB     = 0;
  localparam int IMM_LSB     = 0;
  localparam int REG_FIELD_W = 4;
  localparam int IMM_W       = 16;

  function automatic logic is_alu(input opcode_t op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR};
  endfunction

endpackage

// File: rtl/cpu_gen2_regfile.sv
// cpu_gen2_regfile: NREGS x DATA_W registers, two asynchronous read ports,
// one synchronous write port, asynchronous active-low clear.
module cpu_gen2_regfile
  import cpu_gen2_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 8,
  localparam int IDX_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  ra_idx,
  input  logic [IDX_W-1:0]  rb_idx,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs <= '{default: '0};
    end else if (wr_en) begin
      regs[wr_idx] <= wr_data;
    end
  end

  assign ra_data = regs[ra_idx];
  assign rb_data = regs[rb_idx];

endmodule

// File: rtl/cpu_gen2.sv
// cpu_gen2: multi-cycle FETCH/DECODE/EXEC/MEM/WB core with a single memory port.
// Define CPU_GEN2_BRANCH_EN to enable BEQ/BNE; otherwise they decode as undefined.
module cpu_gen2
  import cpu_gen2_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] MAR,
  output logic [DATA_W-1:0] MBR_W,
  input  logic [DATA_W-1:0] MBR_R,
  output logic              mem_rd,
  output logic              write,
  input  logic              mem_ready,
  output logic [3:0]        flags,
  output logic              halted
);

  localparam int IDX_W = $clog2(NREGS);
  localparam int MSB   = DATA_W - 1;

  logic [2:0]             state;
  logic [ADDR_W-1:0]      pc;
  logic [31:0]            ir;
  logic [DATA_W-1:0]      op_a, op_b, result;
  logic [DATA_W-1:0]      ra_data, rb_data;
  opcode_t                opcode;
  logic [REG_FIELD_W-1:0] rd_f, rs1_f, rs2_f;
  logic [IMM_W-1:0]       imm;
  logic [ADDR_W-1:0]      addr;

  assign opcode = ir[OP_LSB +: 8];
  assign rd_f   = ir[RD_LSB +: REG_FIELD_W];
  assign rs1_f  = ir[RS1_LSB +: REG_FIELD_W];
  assign rs2_f  = ir[RS2_LSB +: REG_FIELD_W];
  assign imm    = ir[IMM_LSB +: IMM_W];
  assign addr   = imm[ADDR_W-1:0];

  cpu_gen2_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .ra_idx  (rs1_f[IDX_W-1:0]),
    .rb_idx  (rs2_f[IDX_W-1:0]),
    .ra_data (ra_data),
    .rb_data (rb_data),
    .wr_en   (state == S_WB),
    .wr_idx  (rd_f[IDX_W-1:0]),
    .wr_data (result)
  );

  logic [DATA_W:0]     sum, diff;
  logic [2*DATA_W-1:0] shl_w, shr_w;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c, alu_o;
  logic [3:0]          alu_flags;

  // Double-width shifts: the bit adjacent to the kept half is the last bit shifted out
  assign sum   = {1'b0, op_a} + {1'b0, op_b};
  assign diff  = {1'b0, op_a} - {1'b0, op_b};
  assign shl_w = {{DATA_W{1'b0}}, op_a} << op_b[5:0];
  assign shr_w = {op_a, {DATA_W{1'b0}}} >> op_b[5:0];

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    case (opcode)
      OP_ADD: begin
        {alu_c, alu_res} = sum;
        alu_o = (op_a[MSB] == op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
      end
      OP_SUB: begin
        {alu_c, alu_res} = diff;
        alu_o = (op_a[MSB] != op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
      end
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_XOR: alu_res = op_a ^ op_b;
      OP_SHL: begin
        alu_res = shl_w[DATA_W-1:0];
        alu_c   = shl_w[DATA_W];
      end
      OP_SHR: begin
        alu_res = shr_w[2*DATA_W-1:DATA_W];
        alu_c   = shr_w[DATA_W-1];
      end
      default: ;
    endcase
  end

  assign alu_flags = {alu_c, alu_res[MSB], alu_o, (alu_res == '0)};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_FETCH;
      pc     <= '0;
      ir     <= '0;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      flags  <= '0;
    end else begin
      case (state)
        S_FETCH: if (mem_ready) begin
          ir    <= MBR_R[31:0];
          pc    <= pc + ADDR_W'(1);
          state <= S_DECODE;
        end
        S_DECODE: begin
          op_a <= ra_data;
          op_b <= rb_data;
          if (is_alu(opcode) || (opcode inside {OP_LDI, OP_LD, OP_ST, OP_JMP})) state <= S_EXEC;
`ifdef CPU_GEN2_BRANCH_EN
          else if (opcode inside {OP_BEQ, OP_BNE}) state <= S_EXEC;
`endif
          else state <= S_HALT;
        end
        S_EXEC: begin
          state <= S_FETCH;
          if (is_alu(opcode)) begin
            result <= alu_res;
            flags  <= alu_flags;
            state  <= S_WB;
          end else if (opcode == OP_LDI) begin
            result <= DATA_W'(imm);
            state  <= S_WB;
          end else if (opcode == OP_LD || opcode == OP_ST) begin
            state <= S_MEM;
          end else if (opcode == OP_JMP) begin
            pc <= addr;
          end
`ifdef CPU_GEN2_BRANCH_EN
          // Only BEQ/BNE remain: take BEQ on equal, BNE on unequal
          else if ((opcode == OP_BEQ) == (op_a == op_b)) begin
            pc <= addr;
          end
`endif
        end
        S_MEM: if (mem_ready) begin
          if (opcode == OP_LD) begin
            result <= MBR_R;
            state  <= S_WB;
          end else begin
            state <= S_FETCH;
          end
        end
        S_WB:    state <= S_FETCH;
        S_HALT:  state <= S_HALT;
        default: state <= S_HALT;
      endcase
    end
  end

  // Requests are decoded from state and gated by reset so an abort drops them at once
  always_comb begin
    mem_rd = 1'b0;
    write  = 1'b0;
    MAR    = '0;
    MBR_W  = '0;
    if (reset) begin
      case (state)
        S_FETCH: begin
          mem_rd = 1'b1;
          MAR    = pc;
        end
        S_MEM: begin
          MAR = addr;
          if (opcode == OP_ST) begin
            write = 1'b1;
            MBR_W = op_a;
          end else begin
            mem_rd = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign halted = (state == S_HALT);

  logic unused_bits;
  assign unused_bits = ^{rd_f, rs1_f, rs2_f, imm, MBR_R, shl_w, shr_w};

endmodule

// File: tb/tb_cpu_gen2.sv
// tb_cpu_gen2: directed programs against a bench-side word memory; expected
// results, flags and cycle counts are hand-computed constants.
module tb_cpu_gen2;
  import cpu_gen2_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam int NREGS  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              mem_ready = 1'b1;
  logic [ADDR_W-1:0] MAR;
  logic [DATA_W-1:0] MBR_W, MBR_R;
  logic              mem_rd, write, halted;
  logic [3:0]        flags;

  logic [31:0] mem [0:65535];
  int checks = 0;
  int fails  = 0;
  int n_cyc  = 0;

  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] res;
    logic [3:0]  fl;
  } vec_t;
  vec_t vecs [0:10];
  logic [3:0] vi;

  always #5 clk = ~clk;

  assign MBR_R = mem[MAR];

  cpu_gen2 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) dut (
    .clk       (clk),
    .reset     (reset),
    .MAR       (MAR),
    .MBR_W     (MBR_W),
    .MBR_R     (MBR_R),
    .mem_rd    (mem_rd),
    .write     (write),
    .mem_ready (mem_ready),
    .flags     (flags),
    .halted    (halted)
  );

  function automatic logic [31:0] ins(input logic [7:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  function automatic logic [31:0] alu(input logic [7:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2);
    return {op, rd, rs1, 12'h000, rs2};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: memory commits a write seen before the edge; outputs sampled 1 unit after
  task automatic tick();
    logic        do_wr;
    logic [15:0] wa;
    logic [31:0] wd;
    do_wr = (write === 1'b1) && (mem_ready === 1'b1);
    wa = MAR;
    wd = MBR_W;
    check("excl_rd_wr", 64'(mem_rd & write), 64'h0);
    @(posedge clk);
    if (do_wr) mem[wa] = wd;
    #1;
    n_cyc++;
  endtask

  task automatic restart();
    mem_ready = 1'b1;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_cyc = 0;
    #1;
  endtask

  task automatic run_until_halt(input int budget);
    while (halted !== 1'b1 && n_cyc < budget) tick();
  endtask

  initial begin
    vecs[0]  = '{OP_ADD, 16'd5,    16'd7,    32'd12,         4'b0000};
    vecs[1]  = '{OP_SUB, 16'd3,    16'd3,    32'd0,          4'b0001};
    vecs[2]  = '{OP_SUB, 16'd0,    16'd1,    32'hFFFF_FFFF,  4'b1100};
    vecs[3]  = '{OP_AND, 16'hF0F0, 16'hFF00, 32'h0000_F000,  4'b0000};
    vecs[4]  = '{OP_OR,  16'h0F00, 16'h00F0, 32'h0000_0FF0,  4'b0000};
    vecs[5]  = '{OP_XOR, 16'hAAAA, 16'hAAAA, 32'd0,          4'b0001};
    vecs[6]  = '{OP_SHR, 16'd3,    16'd1,    32'd1,          4'b1000};
    vecs[7]  = '{OP_SHR, 16'h8001, 16'd40,   32'd0,          4'b0001};
    vecs[8]  = '{OP_SHL, 16'hFFFF, 16'd16,   32'hFFFF_0000,  4'b0100};
    vecs[9]  = '{OP_SHL, 16'h8000, 16'd17,   32'd0,          4'b1001};
    vecs[10] = '{OP_SHL, 16'd1,    16'd32,   32'd0,          4'b1001};

    mem = '{default: '0};
    #2 reset = 1'b0;
    #1;
    check("rst.mem_rd", 64'(mem_rd), 64'h0);
    check("rst.write",  64'(write),  64'h0);
    check("rst.MAR",    64'(MAR),    64'h0);
    check("rst.MBR_W",  64'(MBR_W),  64'h0);
    check("rst.flags",  64'(flags),  64'h0);
    check("rst.halted", 64'(halted), 64'h0);
    tick();
    reset = 1'b1;
    #1;
    check("first_fetch.mem_rd", 64'(mem_rd), 64'h1);
    check("first_fetch.MAR",    64'(MAR),    64'h0);

    // LDI r1,a; LDI r2,b; OP r3,r1,r2; ST r3,0x0100; HLT
    for (int i = 0; i < 11; i++) begin
      vi = 4'(i);
      mem = '{default: '0};
      mem[16'h0000] = ins(OP_LDI, 4'd1, 4'd0, vecs[vi].a);
      mem[16'h0001] = ins(OP_LDI, 4'd2, 4'd0, vecs[vi].b);
      mem[16'h0002] = alu(vecs[vi].op, 4'd3, 4'd1, 4'd2);
      mem[16'h0003] = ins(OP_ST, 4'd0, 4'd3, 16'h0100);
      mem[16'h0004] = ins(OP_HLT, 4'd0, 4'd0, 16'h0000);
      restart();
      run_until_halt(100);
      check($sformatf("alu%0d.result", i), 64'(mem[16'h0100]), 64'(vecs[vi].res));
      check($sformatf("alu%0d.flags", i),  64'(flags),         64'(vecs[vi].fl));
      check($sformatf("alu%0d.cycles", i), 64'(n_cyc),         64'd18);
      check($sformatf("alu%0d.halted", i), 64'(halted),        64'h1);
      check($sformatf("alu%0d.halt_req", i), 64'({mem_rd, write}), 64'h0);
    end

    mem = '{default: '0};
    mem[16'h0000] = ins(OP_LDI, 4'd1, 4'd0, 16'hFFFF);
    mem[16'h0001] = ins(OP_LDI, 4'd2, 4'd0, 16'd16);
    mem[16'h0002] = alu(OP_SHL, 4'd1, 4'd1, 4'd2);
    mem[16'h0003] = alu(OP_ADD, 4'd1, 4'd1, 4'd1);
    mem[16'h0004] = ins(OP_ST, 4'd0, 4'd1, 16'h0200);
    mem[16'h0005] = ins(OP_HLT, 4'd0, 4'd0, 16'h0000);
    restart();
    run_until_halt(100);
    check("shl_add.result", 64'(mem[16'h0200]), 64'hFFFE_0000);
    check("shl_add.flags",  64'(flags),         64'b1100);
    check("shl_add.cycles", 64'(n_cyc),         64'd22);

    mem = '{default: '0};
    mem[16'h0000] = ins(OP_LDI, 4'd1, 4'd0, 16'h4000);
    mem[16'h0001] = ins(OP_LDI, 4'd2, 4'd0, 16'd16);
    mem[16'h0002] = alu(OP_SHL, 4'd1, 4'd1, 4'd2);
    mem[16'h0003] = alu(OP_ADD, 4'd3, 4'd1, 4'd1);
    mem[16'h0004] = ins(OP_ST, 4'd0, 4'd3, 16'h0100);
    mem[16'h0005] = ins(OP_HLT, 4'd0, 4'd0, 16'h0000);
    restart();
    run_until_halt(100);
    check("ovf.result", 64'(mem[16'h0100]), 64'h8000_0000);
    check("ovf.flags",  64'(flags),         64'b0110);

    // r3 held 0x80000000 before this reset; it must read back cleared
    mem = '{default: '0};
    mem[16'h0000] = ins(OP_ST, 4'd0, 4'd3, 16'h0500);
    mem[16'h0001] = ins(OP_HLT, 4'd0, 4'd0, 16'h0000);
    mem[16'h0500] = 32'hFFFF_FFFF;
    restart();
    run_until_halt(100);
    check("regclear.r3", 64'(mem[16'h0500]), 64'h0);

    mem = '{default: '0};
    mem[16'h0000] = ins(OP_LD, 4'd4, 4'd0, 16'h0300);
    mem[16'h0001] = ins(OP_ST, 4'd0, 4'd4, 16'h0301);
    mem[16'h0002] = ins(OP_HLT, 4'd0, 4'd0, 16'h0000);
    mem[16'h0300] = 32'hDEAD_BEEF;
    restart();
    while (!(mem_rd === 1'b1 && MAR === 16'h0300) && n_cyc < 20) tick();
    check("ld.req_cycle", 64'(n_cyc), 64'd3);
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("ld.stall%0d.MAR", k),    64'(MAR),    64'h0300);
      check($sformatf("ld.stall%0d.mem_rd", k), 64'(mem_rd), 64'h1);
      check($sformatf("ld.stall%0d.write", k),  64'(write),  64'h0);
      tick();
    end
    mem_ready = 1'b1;
    run_until_halt(60);
    check("ld.total_cycles", 64'(n_cyc), 64'd14);
    check("ld.data", 64'(mem[16'h0301]), 64'hDEAD_BEEF);

    mem = '{default: '0};
    mem[16'h0000] = ins(OP_LDI, 4'd1, 4'd0, 16'h0055);
    mem[16'h0001] = ins(OP_ST, 4'd0, 4'd1, 16'h0400);
    mem[16'h0002] = ins(OP_HLT, 4'd0, 4'd0, 16'h0000);
    mem[16'h0400] = 32'h1234_5678;
    restart();
    while (write !== 1'b1 && n_cyc < 20) tick();
    check("st.req_cycle", 64'(n_cyc), 64'd7);
    check("st.MAR",       64'(MAR),   64'h0400);
    check("st.MBR_W",     64'(MBR_W), 64'h55);
    mem_ready = 1'b0;
    tick();
    check("st.stall.write", 64'(write), 64'h1);
    check("st.stall.MAR",   64'(MAR),   64'h0400);
    reset = 1'b0;
    #1;
    check("st_abort.write",  64'(write),  64'h0);
    check("st_abort.mem_rd", 64'(mem_rd), 64'h0);
    check("st_abort.MAR",    64'(MAR),    64'h0);
    check("st_abort.MBR_W",  64'(MBR_W),  64'h0);
    tick();
    check("st_abort.mem", 64'(mem[16'h0400]), 64'h1234_5678);
    mem_ready = 1'b1;
    reset = 1'b1;
    n_cyc = 0;
    #1;
    check("st_abort.refetch_rd",  64'(mem_rd), 64'h1);
    check("st_abort.refetch_MAR", 64'(MAR),    64'h0);
    run_until_halt(60);
    check("st_abort.rerun_cycles", 64'(n_cyc), 64'd10);
    check("st_abort.rerun_mem", 64'(mem[16'h0400]), 64'h55);

    mem = '{default: '0};
    mem[16'h0000] = ins(OP_JMP, 4'd0, 4'd0, 16'hFFFF);
    mem[16'hFFFF] = ins(OP_LDI, 4'd1, 4'd0, 16'h0009);
    restart();
    repeat (3) tick();
    check("jmp.MAR",    64'(MAR),    64'hFFFF);
    check("jmp.mem_rd", 64'(mem_rd), 64'h1);
    repeat (4) tick();
    check("pc_wrap.MAR",    64'(MAR),    64'h0000);
    check("pc_wrap.mem_rd", 64'(mem_rd), 64'h1);

    // Target 0x0012: the rs2 field is addr[3:0], so this also selects r2
    mem = '{default: '0};
    mem[16'h0000] = ins(OP_LDI, 4'd1, 4'd0, 16'd1);
    mem[16'h0001] = ins(OP_LDI, 4'd2, 4'd0, 16'd2);
    mem[16'h0002] = ins(OP_BNE, 4'd0, 4'd1, 16'h0012);
    restart();
`ifdef CPU_GEN2_BRANCH_EN
    repeat (11) tick();
    check("bne_taken.MAR",    64'(MAR),    64'h0012);
    check("bne_taken.mem_rd", 64'(mem_rd), 64'h1);
`else
    run_until_halt(40);
    check("bne_undef.halted", 64'(halted), 64'h1);
    check("bne_undef.cycles", 64'(n_cyc),  64'd10);
`endif

    mem[16'h0000] = ins(OP_LDI, 4'd1, 4'd0, 16'd2);
    restart();
`ifdef CPU_GEN2_BRANCH_EN
    repeat (11) tick();
    check("bne_fall.MAR",    64'(MAR),    64'h0003);
    check("bne_fall.halted", 64'(halted), 64'h0);
`else
    run_until_halt(40);
    check("bne_undef2.halted", 64'(halted), 64'h1);
    check("bne_undef2.req",    64'({mem_rd, write}), 64'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
